// File: rtl/kw_stream_upsizer_pkg.sv
// Shared stream definitions for the narrow-to-wide upsizer: default widths,
// the beat record, the FILL/HOLD state type and the slot-index width helper.
package kw_stream_upsizer_pkg;

    localparam int KW_IN_WIDTH = 16;
    localparam int KW_RATIO    = 4;

    typedef struct packed {
        logic [KW_IN_WIDTH-1:0] data;
        logic                   last;
    } kw_beat_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } kw_state_t;

    // Slot counter width; a RATIO of 2 still needs one bit.
    function automatic int kw_slot_w(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/kw_stream_upsizer.sv
// Packs RATIO narrow beats LSB-first into one wide word with per-slot keep flags;
// i_last closes a word early. Accepts a new beat in the cycle the held word drains.
module kw_stream_upsizer
    import kw_stream_upsizer_pkg::*;
#(
    parameter int IN_WIDTH  = KW_IN_WIDTH,
    parameter int RATIO     = KW_RATIO,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic [RATIO-1:0]     o_keep,
    output logic                 o_last
);

    localparam int CNT_W = kw_slot_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

    if (RATIO < 2) begin : g_ratio_chk
        $error("kw_stream_upsizer: RATIO must be at least 2");
    end

    typedef struct packed {
        logic [IN_WIDTH-1:0] data;
        logic                last;
    } beat_t;

    beat_t                beat;
    kw_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, slot;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [RATIO-1:0]     keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 drain, accept;

    assign beat    = '{data: i_data, last: i_last};
    assign o_valid = (state_q == ST_HOLD);
    assign o_data  = data_q;
    assign o_keep  = keep_q;
    assign o_last  = last_q;

    // Held off during reset so nothing is taken before the packer is clean.
    assign i_ready = reset_n && (!o_valid || o_ready);
    assign drain   = o_valid && o_ready;
    assign accept  = i_valid && i_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        slot    = cnt_q;
        if (drain) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
            slot    = '0;
        end
        if (accept) begin
            for (int k = 0; k < RATIO; k++) begin
                if (slot == CNT_W'(k)) begin
                    data_d[k*IN_WIDTH +: IN_WIDTH] = beat.data;
                    keep_d[k]                      = 1'b1;
                end
            end
            if (slot == LAST_SLOT || beat.last) begin
                state_d = ST_HOLD;
                last_d  = beat.last;
                cnt_d   = '0;
            end else begin
                cnt_d = slot + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_kw_stream_upsizer.sv
// Directed and randomized bench for kw_stream_upsizer against a queue-based
// packing model (IN_WIDTH=16, RATIO=4).
module tb_kw_stream_upsizer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_data = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [63:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [15:0] cur[$];
    bit          pend_v = 1'b0;
    logic [63:0] pend_data = '0;
    logic [3:0]  pend_keep = '0;
    logic        pend_last = 1'b0;

    kw_stream_upsizer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] q[$]);
        logic [63:0] w = '0;
        foreach (q[k]) w = w | (64'(q[k]) << (16 * k));
        return w;
    endfunction

    function automatic logic [3:0] keep_of(input int n);
        return 4'((1 << n) - 1);
    endfunction

    // Drive one cycle, compare visible outputs with the model, advance model and clock.
    task automatic cycle(input logic v, input logic [15:0] d, input logic l, input logic r);
        bit rdy;
        i_valid = v; i_data = d; i_last = l; o_ready = r;
        #1;
        rdy = !pend_v || r;
        check("o_valid", 64'(o_valid), 64'(pend_v));
        check("i_ready", 64'(i_ready), 64'(rdy));
        if (pend_v) begin
            check("o_data", o_data, pend_data);
            check("o_keep", 64'(o_keep), 64'(pend_keep));
            check("o_last", 64'(o_last), 64'(pend_last));
        end else begin
            check("o_data_fill", o_data, pack(cur));
            check("o_keep_fill", 64'(o_keep), 64'(keep_of(cur.size())));
            check("o_last_fill", 64'(o_last), 64'd0);
        end
        if (pend_v && r) pend_v = 1'b0;
        if (v && rdy) begin
            cur.push_back(d);
            if (cur.size() == 4 || l) begin
                pend_data = pack(cur);
                pend_keep = keep_of(cur.size());
                pend_last = l;
                pend_v    = 1'b1;
                cur.delete();
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_i_ready", 64'(i_ready), 64'd0);
        check("rst_o_data",  o_data, 64'd0);
        check("rst_o_keep",  64'(o_keep), 64'd0);
        check("rst_o_last",  64'(o_last), 64'd0);
        cur.delete();
        pend_v = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("rel_i_ready", 64'(i_ready), 64'd1);
    endtask

    initial begin
        o_ready = 1'b1;
        reset_pulse();
        @(posedge clock);
        #1;

        // Full word with last on the fourth beat
        cycle(1, 16'h1111, 0, 1);
        cycle(1, 16'h2222, 0, 1);
        cycle(1, 16'h3333, 0, 1);
        cycle(1, 16'h4444, 1, 1);
        check("full_data", o_data, 64'h4444_3333_2222_1111);
        check("full_keep", 64'(o_keep), 64'b1111);
        check("full_last", 64'(o_last), 64'd1);

        // Short word closed by last
        cycle(1, 16'hAAAA, 0, 1);
        cycle(1, 16'hBBBB, 1, 1);
        check("short_data", o_data, 64'h0000_0000_BBBB_AAAA);
        check("short_keep", 64'(o_keep), 64'b0011);
        check("short_last", 64'(o_last), 64'd1);

        // Eight back-to-back beats
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 16'(i), 0, 1);
            if (i == 4) check("b2b_w0", o_data, 64'h0004_0003_0002_0001);
        end
        check("b2b_w1", o_data, 64'h0008_0007_0006_0005);
        check("b2b_last", 64'(o_last), 64'd0);

        // Backpressure: word held five cycles, then drains while a new beat enters slot 0
        for (int i = 0; i < 5; i++) cycle(1, 16'hDEAD, 0, 0);
        check("bp_hold", o_data, 64'h0008_0007_0006_0005);
        cycle(1, 16'hC0DE, 0, 1);
        check("bp_slot0", o_data, 64'h0000_0000_0000_C0DE);
        check("bp_keep", 64'(o_keep), 64'b0001);
        cycle(1, 16'hC0DF, 1, 1);
        cycle(0, 16'h0, 0, 1);

        // One-beat word
        cycle(1, 16'h5A5A, 1, 1);
        check("one_data", o_data, 64'h0000_0000_0000_5A5A);
        check("one_keep", 64'(o_keep), 64'b0001);
        cycle(0, 16'hFFFF, 1, 1);

        // Reset during a partial word discards it
        cycle(1, 16'h0101, 0, 1);
        cycle(1, 16'h0202, 0, 1);
        reset_pulse();
        for (int i = 0; i < 3; i++) cycle(0, 16'h0303, 1, 1);

        // Randomized traffic with a mid-traffic reset
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0);
            if (i == 150) reset_pulse();
        end
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
